// File: rtl/pong_game_ctrl_if.sv
// Front-panel signal bundle between the Pong top level and pong_game_ctrl.
// The master side drives buttons, switches and vsync; the slave side (the controller) drives the chip-facing outputs.
interface pong_game_ctrl_if;
    logic       vsync;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_serve;
    logic       sw_angle;
    logic       sw_speed;
    logic       sw_batsize;
    logic       sw_autoserve;
    logic [5:0] sel_n;
    logic       chip_reset_n;
    logic       ball_angle;
    logic       ball_speed;
    logic       bat_size;
    logic       man_serve;
    logic [2:0] game_idx;
    logic       busy;

    modport master (
        output vsync, btn_next, btn_prev, btn_serve,
               sw_angle, sw_speed, sw_batsize, sw_autoserve,
        input  sel_n, chip_reset_n, ball_angle, ball_speed, bat_size,
               man_serve, game_idx, busy
    );

    modport slave (
        input  vsync, btn_next, btn_prev, btn_serve,
               sw_angle, sw_speed, sw_batsize, sw_autoserve,
        output sel_n, chip_reset_n, ball_angle, ball_speed, bat_size,
               man_serve, game_idx, busy
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Front-panel controller for the ay38500NTSC: debounced game stepping, frame-aligned options, chip reset hold.
// Define PONG_CTRL_SKIP_RIFLE_EN to restrict the game cycle to games 0..3 (rifle games unreachable).
module pong_game_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int RESET_HOLD_FRAMES = 2
) (
    input  logic            clk,
    input  logic            reset,
    pong_game_ctrl_if.slave bus
);

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1);
    localparam int                FC_W    = $clog2(RESET_HOLD_FRAMES + 1);
    localparam logic [FC_W-1:0]   FC_HOLD = FC_W'(RESET_HOLD_FRAMES);
    localparam logic [FC_W-1:0]   FC_ONE  = FC_W'(1);
`ifdef PONG_CTRL_SKIP_RIFLE_EN
    localparam logic [2:0]        LAST_GAME = 3'd3;
`else
    localparam logic [2:0]        LAST_GAME = 3'd5;
`endif

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_CHANGE = 1'b1
    } state_t;

    function automatic logic [5:0] sel_decode(input logic [2:0] idx);
        logic [5:0] sel;
        sel = 6'b111111;
        for (int g = 0; g < 6; g++) begin
            if (idx == 3'(g)) sel[g] = 1'b0;
        end
`ifdef PONG_CTRL_SKIP_RIFLE_EN
        sel[5:4] = 2'b11;
`endif
        return sel;
    endfunction

    // Button order in the debounce vectors: bit0 next, bit1 prev, bit2 serve.
    logic [2:0]            btn_raw;
    logic [2:0]            btn_raw_q;
    logic [2:0]            btn_stable_q;
    logic [2:0]            btn_stable_d;
    logic [2:0]            btn_press_q;
    logic [2:0][DB_W-1:0]  db_cnt_q;
    logic [2:0][DB_W-1:0]  db_cnt_d;

    assign btn_raw = {bus.btn_serve, bus.btn_prev, bus.btn_next};

    always_comb begin
        db_cnt_d     = db_cnt_q;
        btn_stable_d = btn_stable_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_raw[i] != btn_raw_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] != DB_MAX) begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
            if ((btn_raw[i] == btn_raw_q[i]) && (db_cnt_q[i] == DB_MAX)) begin
                btn_stable_d[i] = btn_raw_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_raw_q    <= '0;
            btn_stable_q <= '0;
            btn_press_q  <= '0;
            db_cnt_q     <= '0;
        end else begin
            btn_raw_q    <= btn_raw;
            btn_stable_q <= btn_stable_d;
            btn_press_q  <= btn_stable_d & ~btn_stable_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    logic vsync_q;
    logic frame_tick;
    logic next_press;
    logic prev_press;
    logic serve_press;
    logic step_req;

    assign frame_tick  = bus.vsync & ~vsync_q;
    assign next_press  = btn_press_q[0];
    assign prev_press  = btn_press_q[1];
    assign serve_press = btn_press_q[2];
    // Simultaneous next and prev cancel each other out.
    assign step_req    = next_press ^ prev_press;

    logic ball_angle_q;
    logic ball_speed_q;
    logic bat_size_q;
    logic auto_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            ball_angle_q <= 1'b0;
            ball_speed_q <= 1'b0;
            bat_size_q   <= 1'b0;
            auto_q       <= 1'b0;
        end else begin
            vsync_q <= bus.vsync;
            if (frame_tick) begin
                ball_angle_q <= bus.sw_angle;
                ball_speed_q <= bus.sw_speed;
                bat_size_q   <= bus.sw_batsize;
                auto_q       <= bus.sw_autoserve;
            end
        end
    end

    state_t          state_q;
    logic [FC_W-1:0] frame_cnt_q;
    logic [FC_W-1:0] frame_cnt_inc;
    logic [2:0]      game_idx_q;
    logic [2:0]      idx_up;
    logic [2:0]      idx_dn;
    logic [5:0]      sel_n_q;
    logic            chip_reset_n_q;
    logic            busy_q;
    logic            serve_pending_q;
    logic            man_serve_q;

    assign frame_cnt_inc = frame_cnt_q + FC_ONE;
    assign idx_up        = (game_idx_q == LAST_GAME) ? 3'd0 : game_idx_q + 3'd1;
    assign idx_dn        = (game_idx_q == 3'd0) ? LAST_GAME : game_idx_q - 3'd1;

    // chip_reset_n drops on the edge that enters CHANGE but only rises one cycle after RUN is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_CHANGE;
            frame_cnt_q     <= '0;
            game_idx_q      <= 3'd0;
            sel_n_q         <= 6'b111110;
            chip_reset_n_q  <= 1'b0;
            busy_q          <= 1'b1;
            serve_pending_q <= 1'b0;
            man_serve_q     <= 1'b0;
        end else begin
            sel_n_q <= sel_decode(game_idx_q);
            case (state_q)
                ST_RUN: begin
                    if (step_req) begin
                        game_idx_q      <= next_press ? idx_up : idx_dn;
                        frame_cnt_q     <= '0;
                        state_q         <= ST_CHANGE;
                        chip_reset_n_q  <= 1'b0;
                        busy_q          <= 1'b1;
                        serve_pending_q <= 1'b0;
                        man_serve_q     <= 1'b0;
                    end else begin
                        chip_reset_n_q <= 1'b1;
                        busy_q         <= 1'b0;
                        if (frame_tick) begin
                            // A pending serve becomes a one-frame pulse; the pulse ends at the next tick.
                            man_serve_q     <= serve_pending_q & ~bus.sw_autoserve;
                            serve_pending_q <= serve_press & ~serve_pending_q & ~man_serve_q
                                               & ~bus.sw_autoserve;
                        end else if (serve_press && !auto_q && !serve_pending_q && !man_serve_q) begin
                            serve_pending_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    chip_reset_n_q  <= 1'b0;
                    serve_pending_q <= 1'b0;
                    man_serve_q     <= 1'b0;
                    if (frame_tick) begin
                        frame_cnt_q <= frame_cnt_inc;
                        if (frame_cnt_inc == FC_HOLD) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.sel_n        = sel_n_q;
    assign bus.chip_reset_n = chip_reset_n_q;
    assign bus.ball_angle   = ball_angle_q;
    assign bus.ball_speed   = ball_speed_q;
    assign bus.bat_size     = bat_size_q;
    assign bus.man_serve    = man_serve_q;
    assign bus.game_idx     = game_idx_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: button vector table plus scoreboard of expected game changes.
module tb_pong_game_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam int VPER = 20;
`ifdef PONG_CTRL_SKIP_RIFLE_EN
    localparam int MAXG = 3;
`else
    localparam int MAXG = 5;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vcnt     = 5;
    int   cur_idx  = 0;

    typedef struct { int idx; int sel; } sb_t;
    sb_t sb_q[$];

    typedef struct { string name; bit nx; bit pv; int hold; int exp_idx; } vec_t;
    vec_t vt [6];

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .DEBOUNCE_CYCLES   (DEB),
        .RESET_HOLD_FRAMES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int sel_of(input int idx);
        return 63 & ~(1 << idx);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vcnt(input int n);
        for (int i = 0; i < VPER + 2; i++) begin
            tick_clk();
            if (vcnt == n) break;
        end
    endtask

    task automatic press(input bit nx, input bit pv, input bit sv, input int hold);
        bus.btn_next  = nx;
        bus.btn_prev  = pv;
        bus.btn_serve = sv;
        repeat (hold) tick_clk();
        bus.btn_next  = 1'b0;
        bus.btn_prev  = 1'b0;
        bus.btn_serve = 1'b0;
    endtask

    task automatic push_exp(input int idx);
        sb_t e;
        e.idx = idx;
        e.sel = sel_of(idx);
        sb_q.push_back(e);
    endtask

    task automatic wait_busy(input int val, output int ok);
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            if (int'(bus.busy) == val) begin
                ok = 1;
                break;
            end
            tick_clk();
        end
    endtask

    // Follows a CHANGE period until chip_reset_n rises, counting frame ticks seen while it is low.
    task automatic check_run(input string tag, input int exp_sel);
        logic vp;
        int   rises;
        int   reached;
        int   last_busy;
        int   sel_bad;
        rises = 0; reached = 0; sel_bad = 0;
        last_busy = int'(bus.busy);
        vp = bus.vsync;
        for (int i = 0; i < 200; i++) begin
            tick_clk();
            if (bus.chip_reset_n) begin
                reached = 1;
                break;
            end
            if (bus.vsync && !vp) rises++;
            if (int'(bus.sel_n) != exp_sel) sel_bad++;
            last_busy = int'(bus.busy);
            vp = bus.vsync;
        end
        check({tag, "_run_reached"}, reached, 1);
        check({tag, "_hold_frames"}, rises, HOLD);
        check({tag, "_busy_before_release"}, last_busy, 0);
        check({tag, "_sel_during_hold"}, sel_bad, 0);
    endtask

    initial begin
        bus.vsync = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            vcnt = (vcnt == VPER - 1) ? 0 : vcnt + 1;
            bus.vsync = (vcnt < 4);
        end
    end

    // Scoreboard: every entry into CHANGE must match the oldest expected game change.
    initial begin
        logic bprev;
        sb_t  e;
        bprev = 1'b1;
        forever begin
            tick_clk();
            if (!reset && bus.busy && !bprev) begin
                check("sb_expect_pending", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_game_idx", int'(bus.game_idx), e.idx);
                    check("sb_chip_reset_low", int'(bus.chip_reset_n), 0);
                    tick_clk();
                    check("sb_sel_n", int'(bus.sel_n), e.sel);
                end
            end
            bprev = bus.busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ok;
        int   exp;
        int   errs;
        int   rose;
        int   newv;
        int   found;
        int   at_tick;
        int   hi;
        int   cnt;
        logic vp;

        vt[0] = '{"glitch_next",    1'b1, 1'b0, 3, 0};
        vt[1] = '{"next_hold",      1'b1, 1'b0, 6, 1};
        vt[2] = '{"prev_back",      1'b0, 1'b1, 6, 0};
        vt[3] = '{"prev_wrap",      1'b0, 1'b1, 6, MAXG};
        vt[4] = '{"next_wrap",      1'b1, 1'b0, 6, 0};
        vt[5] = '{"next_prev_same", 1'b1, 1'b1, 6, 0};

        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_serve = 1'b0;
        bus.sw_angle = 1'b0; bus.sw_speed = 1'b0; bus.sw_batsize = 1'b0; bus.sw_autoserve = 1'b0;

        // Power-up
        repeat (3) tick_clk();
        check("rst_game_idx",     int'(bus.game_idx), 0);
        check("rst_sel_n",        int'(bus.sel_n), 6'b111110);
        check("rst_chip_reset_n", int'(bus.chip_reset_n), 0);
        check("rst_busy",         int'(bus.busy), 1);
        check("rst_ball_angle",   int'(bus.ball_angle), 0);
        check("rst_ball_speed",   int'(bus.ball_speed), 0);
        check("rst_bat_size",     int'(bus.bat_size), 0);
        check("rst_man_serve",    int'(bus.man_serve), 0);
        wait_vcnt(10);
        reset = 1'b0;
        check_run("powerup", sel_of(0));
        tick_clk();
        check("powerup_busy_low", int'(bus.busy), 0);

        // Button vector table
        for (int i = 0; i < 6; i++) begin
            press(vt[i].nx, vt[i].pv, 1'b0, vt[i].hold);
            if (vt[i].exp_idx != cur_idx) begin
                push_exp(vt[i].exp_idx);
                wait_busy(1, ok);
                check({vt[i].name, "_busy_rise"}, ok, 1);
                check_run(vt[i].name, sel_of(vt[i].exp_idx));
            end else begin
                repeat (12) tick_clk();
                check({vt[i].name, "_stays_run"}, int'(bus.busy), 0);
            end
            check({vt[i].name, "_game_idx"}, int'(bus.game_idx), vt[i].exp_idx);
            check({vt[i].name, "_sel_n"}, int'(bus.sel_n), sel_of(vt[i].exp_idx));
            cur_idx = vt[i].exp_idx;
        end

        // Next pressed again while in CHANGE is discarded
        exp = (cur_idx == MAXG) ? 0 : cur_idx + 1;
        wait_vcnt(2);
        press(1'b1, 1'b0, 1'b0, 6);
        push_exp(exp);
        wait_busy(1, ok);
        check("next_in_change_busy", ok, 1);
        press(1'b1, 1'b0, 1'b0, 6);
        check_run("next_in_change", sel_of(exp));
        repeat (12) tick_clk();
        check("next_in_change_idx", int'(bus.game_idx), exp);
        check("next_in_change_busy_low", int'(bus.busy), 0);
        cur_idx = exp;

        // Options only follow their switches on frame ticks
        for (int k = 0; k < 2; k++) begin
            newv = (k == 0) ? 1 : 0;
            errs = 0;
            rose = 0;
            wait_vcnt(10);
            bus.sw_speed = newv[0];
            vp = bus.vsync;
            for (int c = 0; c < 30; c++) begin
                tick_clk();
                if (bus.vsync && !vp) rose = 1;
                vp = bus.vsync;
                if (int'(bus.ball_speed) != ((rose != 0) ? newv : 1 - newv)) errs++;
            end
            check("ball_speed_frame_aligned", errs, 0);
            check("ball_speed_final", int'(bus.ball_speed), newv);
            check("ball_angle_untouched", int'(bus.ball_angle), 0);
        end

        // Manual serve: one full frame of man_serve starting on a frame tick
        bus.sw_batsize = 1'b1;
        wait_vcnt(2);
        press(1'b0, 1'b0, 1'b1, 6);
        found = 0; at_tick = 0;
        vp = bus.vsync;
        for (int c = 0; c < 40; c++) begin
            tick_clk();
            if (bus.man_serve) begin
                found = 1;
                at_tick = int'(bus.vsync && !vp);
                break;
            end
            vp = bus.vsync;
        end
        check("serve_asserted", found, 1);
        check("serve_on_frame_tick", at_tick, 1);
        hi = found;
        for (int c = 0; c < 60; c++) begin
            tick_clk();
            if (!bus.man_serve) break;
            hi++;
        end
        check("serve_width", hi, VPER);

        // Auto serve suppresses man_serve
        bus.sw_autoserve = 1'b1;
        wait_vcnt(5);
        wait_vcnt(5);
        press(1'b0, 1'b0, 1'b1, 6);
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            tick_clk();
            if (bus.man_serve) cnt++;
        end
        check("autoserve_no_man_serve", cnt, 0);
        bus.sw_autoserve = 1'b0;
        wait_vcnt(5);
        wait_vcnt(5);

        // Game change while a serve is pending cancels it
        exp = (cur_idx == MAXG) ? 0 : cur_idx + 1;
        wait_vcnt(1);
        press(1'b0, 1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        push_exp(exp);
        wait_busy(1, ok);
        check("pending_change_busy", ok, 1);
        check("pending_change_man_low", int'(bus.man_serve), 0);
        check_run("pending_change", sel_of(exp));
        cnt = 0;
        for (int c = 0; c < 45; c++) begin
            tick_clk();
            if (bus.man_serve) cnt++;
        end
        check("pending_change_no_serve", cnt, 0);
        cur_idx = exp;

        // Reset mid-serve
        wait_vcnt(2);
        press(1'b0, 1'b0, 1'b1, 6);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            tick_clk();
            if (bus.man_serve) begin
                found = 1;
                break;
            end
        end
        check("midserve_asserted", found, 1);
        check("midserve_bat_size_set", int'(bus.bat_size), 1);
        reset = 1'b1;
        tick_clk();
        check("midserve_rst_man_serve", int'(bus.man_serve), 0);
        check("midserve_rst_game_idx",  int'(bus.game_idx), 0);
        check("midserve_rst_sel_n",     int'(bus.sel_n), 6'b111110);
        check("midserve_rst_busy",      int'(bus.busy), 1);
        check("midserve_rst_bat_size",  int'(bus.bat_size), 0);
        wait_vcnt(10);
        reset = 1'b0;
        check_run("after_midserve", sel_of(0));
        cur_idx = 0;

        // Reset mid-CHANGE
        wait_vcnt(2);
        press(1'b1, 1'b0, 1'b0, 6);
        push_exp(1);
        wait_busy(1, ok);
        check("midchange_busy", ok, 1);
        repeat (5) tick_clk();
        reset = 1'b1;
        repeat (2) tick_clk();
        check("midchange_rst_game_idx",     int'(bus.game_idx), 0);
        check("midchange_rst_sel_n",        int'(bus.sel_n), 6'b111110);
        check("midchange_rst_chip_reset_n", int'(bus.chip_reset_n), 0);
        check("midchange_rst_busy",         int'(bus.busy), 1);
        wait_vcnt(10);
        reset = 1'b0;
        check_run("after_midchange", sel_of(0));
        tick_clk();
        check("after_midchange_idx", int'(bus.game_idx), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
